// File: rtl/argon_regfile_mp.sv
// Argon multi-port register file: 2 read ports, 1 write port, SP push/pop, flags port, busy scoreboard.
// Optional same-cycle write forwarding and stall exemption: define REGFILE_BYPASS_EN.

module argon_regfile_cell #(
   parameter int                DATA_W  = 16,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic              i_Clk,
   input  logic              i_Reset_n,
   input  logic              ld,
   input  logic [DATA_W-1:0] d,
   input  logic              busy_set,
   input  logic              busy_clr,
   output logic [DATA_W-1:0] q,
   output logic              busy
);

   // A claim landing with a write to the same register keeps it busy (new owner).
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         q    <= RST_VAL;
         busy <= 1'b0;
      end else begin
         if (ld)
            q <= d;
         if (busy_set)
            busy <= 1'b1;
         else if (busy_clr)
            busy <= 1'b0;
      end
   end

endmodule

module argon_regfile_mp #(
   parameter int          DATA_W   = 16,
   parameter int          NUM_REGS = 8,
   parameter int          IDX_W    = $clog2(NUM_REGS),
   parameter int          SP_STEP  = 2,
   parameter int unsigned SP_RESET = 32'h0000_FFFE
) (
   input  logic              i_Clk,
   input  logic              i_Reset_n,
   input  logic              i_rd_valid,
   input  logic [IDX_W-1:0]  i_rd_idx_a,
   input  logic [IDX_W-1:0]  i_rd_idx_b,
   output logic              o_stall,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data_a,
   output logic [DATA_W-1:0] o_rd_data_b,
   input  logic              i_wr_valid,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_claim_valid,
   input  logic [IDX_W-1:0]  i_claim_idx,
   input  logic [1:0]        i_sp_op,
   output logic [DATA_W-1:0] o_sp,
   input  logic              i_flags_valid,
   input  logic [DATA_W-1:0] i_flags_data,
   output logic [DATA_W-1:0] o_flags
);

   localparam int                SP_IDX  = NUM_REGS - 2;
   localparam int                F_IDX   = NUM_REGS - 1;
   localparam int                STAGES  = 1;
   localparam logic [DATA_W-1:0] SP_RST  = DATA_W'(SP_RESET);
   localparam logic [DATA_W-1:0] STEP    = DATA_W'(SP_STEP);
   localparam logic [1:0]        SP_PUSH = 2'b01;
   localparam logic [1:0]        SP_POP  = 2'b10;

   typedef struct packed {
      logic              vld;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   wr_req_t                         wr;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
   logic [NUM_REGS-1:0]             busy_q;
   logic [NUM_REGS-1:0]             busy_eff;
   logic [NUM_REGS-1:1]             wr_hit;
   logic [DATA_W-1:0]               rd_a;
   logic [DATA_W-1:0]               rd_b;
   logic                            rd_acc;
   logic [STAGES:0]                 vld_pipe;

   // r0 writes are squashed here so nothing downstream needs to special-case index 0
   always_comb begin
      wr.vld  = i_wr_valid && (i_wr_idx != '0);
      wr.idx  = i_wr_idx;
      wr.data = i_wr_data;
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
         assign regs_q[gi] = '0;
         assign busy_q[gi] = 1'b0;
      end else begin : g_cell
         logic              cell_ld;
         logic [DATA_W-1:0] cell_d;
         logic              cell_claim;

         assign wr_hit[gi]  = wr.vld && (wr.idx == IDX_W'(gi));
         assign cell_claim  = i_claim_valid && (i_claim_idx == IDX_W'(gi));

         // General write wins over the dedicated SP / flags update of the same register.
         always_comb begin
            cell_ld = wr_hit[gi];
            cell_d  = wr.data;
            if (!wr_hit[gi]) begin
               if (gi == SP_IDX) begin
                  cell_ld = (i_sp_op == SP_PUSH) || (i_sp_op == SP_POP);
                  cell_d  = (i_sp_op == SP_PUSH) ? regs_q[gi] - STEP : regs_q[gi] + STEP;
               end else if (gi == F_IDX) begin
                  cell_ld = i_flags_valid;
                  cell_d  = i_flags_data;
               end
            end
         end

         argon_regfile_cell #(
            .DATA_W  (DATA_W),
            .RST_VAL ((gi == SP_IDX) ? SP_RST : {DATA_W{1'b0}})
         ) u_cell (
            .i_Clk     (i_Clk),
            .i_Reset_n (i_Reset_n),
            .ld        (cell_ld),
            .d         (cell_d),
            .busy_set  (cell_claim),
            .busy_clr  (wr_hit[gi]),
            .q         (regs_q[gi]),
            .busy      (busy_q[gi])
         );
      end
   end

   always_comb begin
      busy_eff = busy_q;
      rd_a     = regs_q[i_rd_idx_a];
      rd_b     = regs_q[i_rd_idx_b];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NUM_REGS; i++)
         busy_eff[i] = busy_q[i] && !(wr.vld && (wr.idx == IDX_W'(i)));
      if (wr.vld && (wr.idx == i_rd_idx_a))
         rd_a = wr.data;
      if (wr.vld && (wr.idx == i_rd_idx_b))
         rd_b = wr.data;
`endif
   end

   assign o_stall     = i_rd_valid && (busy_eff[i_rd_idx_a] || busy_eff[i_rd_idx_b]);
   assign rd_acc      = i_rd_valid && !o_stall;
   assign vld_pipe[0] = rd_acc;

   // Data outputs hold across refused/idle cycles; only valid drops.
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         vld_pipe[STAGES:1] <= '0;
         o_rd_data_a        <= '0;
         o_rd_data_b        <= '0;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         if (rd_acc) begin
            o_rd_data_a <= rd_a;
            o_rd_data_b <= rd_b;
         end
      end
   end

   assign o_rd_valid = vld_pipe[STAGES];
   assign o_sp       = regs_q[SP_IDX];
   assign o_flags    = regs_q[F_IDX];

endmodule

// File: tb/tb_argon_regfile_mp.sv
// Randomized + directed bench for argon_regfile_mp against a cycle-level architectural model.
module tb_argon_regfile_mp;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 8;
   localparam int IDX_W    = 3;
   localparam int SP_IDX   = 6;
   localparam int F_IDX    = 7;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              i_Clk = 1'b0;
   logic              i_Reset_n;
   logic              i_rd_valid;
   logic [IDX_W-1:0]  i_rd_idx_a, i_rd_idx_b;
   logic              o_stall, o_rd_valid;
   logic [DATA_W-1:0] o_rd_data_a, o_rd_data_b;
   logic              i_wr_valid;
   logic [IDX_W-1:0]  i_wr_idx;
   logic [DATA_W-1:0] i_wr_data;
   logic              i_claim_valid;
   logic [IDX_W-1:0]  i_claim_idx;
   logic [1:0]        i_sp_op;
   logic [DATA_W-1:0] o_sp;
   logic              i_flags_valid;
   logic [DATA_W-1:0] i_flags_data;
   logic [DATA_W-1:0] o_flags;

   argon_regfile_mp dut (
      .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
      .i_rd_valid(i_rd_valid), .i_rd_idx_a(i_rd_idx_a), .i_rd_idx_b(i_rd_idx_b),
      .o_stall(o_stall), .o_rd_valid(o_rd_valid),
      .o_rd_data_a(o_rd_data_a), .o_rd_data_b(o_rd_data_b),
      .i_wr_valid(i_wr_valid), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
      .i_claim_valid(i_claim_valid), .i_claim_idx(i_claim_idx),
      .i_sp_op(i_sp_op), .o_sp(o_sp),
      .i_flags_valid(i_flags_valid), .i_flags_data(i_flags_data), .o_flags(o_flags)
   );

   always #5 i_Clk = ~i_Clk;

   int total = 0;
   int bad   = 0;

   // architectural state
   logic [DATA_W-1:0] m_reg [NUM_REGS];
   bit                m_busy [NUM_REGS];
   logic              m_vld;
   logic [DATA_W-1:0] m_a, m_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < NUM_REGS; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
      m_reg[SP_IDX] = 16'hFFFE;
      m_vld = 1'b0;
      m_a   = '0;
      m_b   = '0;
   endtask

   task automatic idle();
      i_rd_valid = 0; i_rd_idx_a = '0; i_rd_idx_b = '0;
      i_wr_valid = 0; i_wr_idx = '0; i_wr_data = '0;
      i_claim_valid = 0; i_claim_idx = '0;
      i_sp_op = 2'b00; i_flags_valid = 0; i_flags_data = '0;
   endtask

   // Inputs are already applied; checks stall, advances one clock, checks registered outputs.
   task automatic step();
      bit wr, stl, acc, ba, bb;
      wr  = i_wr_valid && (i_wr_idx != 0);
      ba  = m_busy[i_rd_idx_a] && !(BYP && wr && i_wr_idx == i_rd_idx_a);
      bb  = m_busy[i_rd_idx_b] && !(BYP && wr && i_wr_idx == i_rd_idx_b);
      stl = i_rd_valid && (ba || bb);
      #1 chk("stall", o_stall, stl);
      acc   = i_rd_valid && !stl;
      m_vld = acc;
      if (acc) begin
         m_a = (BYP && wr && i_wr_idx == i_rd_idx_a) ? i_wr_data : m_reg[i_rd_idx_a];
         m_b = (BYP && wr && i_wr_idx == i_rd_idx_b) ? i_wr_data : m_reg[i_rd_idx_b];
      end
      if (!(wr && i_wr_idx == SP_IDX)) begin
         if (i_sp_op == 2'b01) m_reg[SP_IDX] = m_reg[SP_IDX] - 16'd2;
         if (i_sp_op == 2'b10) m_reg[SP_IDX] = m_reg[SP_IDX] + 16'd2;
      end
      if (!(wr && i_wr_idx == F_IDX) && i_flags_valid) m_reg[F_IDX] = i_flags_data;
      if (wr) begin
         m_reg[i_wr_idx]  = i_wr_data;
         m_busy[i_wr_idx] = 1'b0;
      end
      if (i_claim_valid && i_claim_idx != 0) m_busy[i_claim_idx] = 1'b1;
      @(posedge i_Clk);
      #1;
      chk("rd_valid", o_rd_valid, m_vld);
      chk("rd_data_a", o_rd_data_a, m_a);
      chk("rd_data_b", o_rd_data_b, m_b);
      chk("sp", o_sp, m_reg[SP_IDX]);
      chk("flags", o_flags, m_reg[F_IDX]);
   endtask

   initial begin
      idle();
      mdl_reset();
      i_Reset_n = 1'b1;
      #2 i_Reset_n = 1'b0;
      #1;
      chk("rst_sp", o_sp, 16'hFFFE);
      chk("rst_flags", o_flags, 0);
      chk("rst_rd_valid", o_rd_valid, 0);
      chk("rst_data_a", o_rd_data_a, 0);
      chk("rst_stall", o_stall, 0);
      repeat (2) @(posedge i_Clk);
      #1 i_Reset_n = 1'b1;

      // read r1/r2 straight after reset
      i_rd_valid = 1; i_rd_idx_a = 3'd1; i_rd_idx_b = 3'd2;
      step();
      chk("post_rst_valid", o_rd_valid, 1);

      // zero register: write and claim r0, then read it
      idle(); i_wr_valid = 1; i_wr_idx = 3'd0; i_wr_data = 16'h1234;
      i_claim_valid = 1; i_claim_idx = 3'd0;
      step();
      idle(); i_rd_valid = 1; i_rd_idx_a = 3'd0; i_rd_idx_b = 3'd0;
      step();
      chk("r0_zero", o_rd_data_a, 0);

      // hazard on r3
      idle(); i_claim_valid = 1; i_claim_idx = 3'd3;
      step();
      idle(); i_rd_valid = 1; i_rd_idx_a = 3'd3; i_rd_idx_b = 3'd1;
      step();
      i_wr_valid = 1; i_wr_idx = 3'd3; i_wr_data = 16'h00AA;
      step();
      idle(); i_rd_valid = 1; i_rd_idx_a = 3'd3; i_rd_idx_b = 3'd3;
      step();
      chk("hazard_data", o_rd_data_a, 16'h00AA);

      // SP wrap
      idle(); i_wr_valid = 1; i_wr_idx = SP_IDX[IDX_W-1:0]; i_wr_data = 16'h0000;
      step();
      idle(); i_sp_op = 2'b01;
      step();
      chk("sp_wrap_push", o_sp, 16'hFFFE);
      i_sp_op = 2'b10;
      step();
      step();
      chk("sp_wrap_pop", o_sp, 16'h0002);
      i_sp_op = 2'b11;
      step();

      // same-cycle priority
      idle(); i_wr_valid = 1; i_wr_idx = SP_IDX[IDX_W-1:0]; i_wr_data = 16'h0100; i_sp_op = 2'b01;
      step();
      chk("prio_sp", o_sp, 16'h0100);
      idle(); i_wr_valid = 1; i_wr_idx = F_IDX[IDX_W-1:0]; i_wr_data = 16'h0005;
      i_flags_valid = 1; i_flags_data = 16'h000F;
      step();
      chk("prio_flags", o_flags, 16'h0005);

      // random traffic
      for (int n = 0; n < 500; n++) begin
         i_rd_valid    = ($urandom_range(1, 0) == 1);
         i_rd_idx_a    = IDX_W'($urandom_range(NUM_REGS-1, 0));
         i_rd_idx_b    = IDX_W'($urandom_range(NUM_REGS-1, 0));
         i_wr_valid    = ($urandom_range(9, 0) < 4);
         i_wr_idx      = IDX_W'($urandom_range(NUM_REGS-1, 0));
         i_wr_data     = DATA_W'($urandom);
         i_claim_valid = ($urandom_range(19, 0) < 3);
         i_claim_idx   = IDX_W'($urandom_range(NUM_REGS-1, 0));
         i_sp_op       = 2'($urandom_range(3, 0));
         i_flags_valid = ($urandom_range(3, 0) == 0);
         i_flags_data  = DATA_W'($urandom);
         step();
      end

      // async reset between edges while r5 is busy
      idle(); i_claim_valid = 1; i_claim_idx = 3'd5;
      step();
      idle(); i_sp_op = 2'b01; i_rd_valid = 1; i_rd_idx_a = 3'd5; i_rd_idx_b = 3'd5;
      #2 i_Reset_n = 1'b0;
      #1;
      chk("mid_rst_sp", o_sp, 16'hFFFE);
      chk("mid_rst_flags", o_flags, 0);
      chk("mid_rst_valid", o_rd_valid, 0);
      chk("mid_rst_data_b", o_rd_data_b, 0);
      chk("mid_rst_stall", o_stall, 0);
      mdl_reset();
      #1 i_Reset_n = 1'b1;
      i_sp_op = 2'b00;
      step();
      chk("r5_after_rst", o_rd_valid, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
